// File: rtl/tmds_decoder.sv
// TMDS receive channel: finds the 10-bit symbol boundary by hunting for runs of
// control tokens, then decodes aligned symbols into video data or control codes.
module tmds_decoder #(
  parameter int LOCK_COUNT = 8,
  parameter int HUNT_LEN   = 1024,
  parameter int LOSS_LEN   = 65536
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] control_out,
  output logic       ve_out,
  output logic       locked_out,
  output logic [3:0] offset_out
);

  localparam int RUN_W  = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int HUNT_W = (HUNT_LEN > 1) ? $clog2(HUNT_LEN) : 1;
  localparam int LOSS_W = (LOSS_LEN > 1) ? $clog2(LOSS_LEN) : 1;

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [HUNT_W-1:0] HUNT_LAST = HUNT_W'(HUNT_LEN - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_LEN - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [9:0]        prev_q, prev_d;
  logic [3:0]        offset_q, offset_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic [HUNT_W-1:0] hunt_cnt_q, hunt_cnt_d;
  logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
  logic [7:0]        data_q, data_d;
  logic [1:0]        control_q, control_d;
  logic              ve_q, ve_d;
  logic              locked_q, locked_d;

  // Offset never exceeds 9, so the top bit of the newest word is never selected
  // directly; it still reaches the window one cycle later through prev.
  logic [18:0] window;
  logic [9:0]  slice [10];
  logic [9:0]  aligned;

  assign window = {tmds_in[8:0], prev_q};

  for (genvar gi = 0; gi < 10; gi++) begin : g_slice
    assign slice[gi] = window[gi+9:gi];
  end

  always_comb begin
    aligned = slice[0];
    for (int i = 1; i < 10; i++) begin
      if (offset_q == 4'(i)) aligned = slice[i];
    end
  end

  logic [7:0] d_bits;
  logic [7:0] decoded;

  assign d_bits     = aligned[9] ? ~aligned[7:0] : aligned[7:0];
  assign decoded[0] = d_bits[0];

  for (genvar gi = 1; gi < 8; gi++) begin : g_dec
    assign decoded[gi] = aligned[8] ? (d_bits[gi] ^ d_bits[gi-1])
                                    : ~(d_bits[gi] ^ d_bits[gi-1]);
  end

  logic       is_token;
  logic [1:0] token_code;

  always_comb begin
    is_token   = 1'b1;
    token_code = 2'b00;
    case (aligned)
      10'h354: token_code = 2'b00;
      10'h0AB: token_code = 2'b01;
      10'h154: token_code = 2'b10;
      10'h2AB: token_code = 2'b11;
      default: is_token   = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = tmds_in;
    offset_d   = offset_q;
    run_cnt_d  = run_cnt_q;
    hunt_cnt_d = hunt_cnt_q;
    loss_cnt_d = loss_cnt_q;

    case (state_q)
      SEARCH: begin
        if (is_token) begin
          if (run_cnt_q == RUN_LAST) begin
            state_d    = LOCKED;
            run_cnt_d  = '0;
            hunt_cnt_d = '0;
            loss_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end else begin
          run_cnt_d = '0;
          if (hunt_cnt_q == HUNT_LAST) begin
            offset_d   = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            hunt_cnt_d = '0;
          end else begin
            hunt_cnt_d = hunt_cnt_q + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (is_token) begin
          loss_cnt_d = '0;
        end else if (loss_cnt_q == LOSS_LAST) begin
          // Resume hunting from the offset that was last good.
          state_d    = SEARCH;
          loss_cnt_d = '0;
          run_cnt_d  = '0;
          hunt_cnt_d = '0;
        end else begin
          loss_cnt_d = loss_cnt_q + 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Outputs follow the lock status being entered, so they agree with locked_out.
  always_comb begin
    data_d    = data_q;
    control_d = control_q;
    ve_d      = 1'b0;
    locked_d  = (state_d == LOCKED);
    if (state_d == LOCKED) begin
      if (is_token) begin
        control_d = token_code;
      end else begin
        ve_d   = 1'b1;
        data_d = decoded;
      end
    end else begin
      control_d = 2'b00;
      data_d    = 8'h00;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= SEARCH;
      prev_q     <= '0;
      offset_q   <= '0;
      run_cnt_q  <= '0;
      hunt_cnt_q <= '0;
      loss_cnt_q <= '0;
      data_q     <= '0;
      control_q  <= '0;
      ve_q       <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      offset_q   <= offset_d;
      run_cnt_q  <= run_cnt_d;
      hunt_cnt_q <= hunt_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      data_q     <= data_d;
      control_q  <= control_d;
      ve_q       <= ve_d;
      locked_q   <= locked_d;
    end
  end

  assign data_out    = data_q;
  assign control_out = control_q;
  assign ve_out      = ve_q;
  assign locked_out  = locked_q;
  assign offset_out  = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: directed symbol streams, a serial-stream reference model
// checked every cycle, a reference TMDS encoder and literal expectations.
module tb_tmds_decoder;

  localparam int LC = 8;
  localparam int HL = 16;
  localparam int LL = 32;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [9:0] tmds_in;
  logic [7:0] data_out;
  logic [1:0] control_out;
  logic       ve_out;
  logic       locked_out;
  logic [3:0] offset_out;

  tmds_decoder #(.LOCK_COUNT(LC), .HUNT_LEN(HL), .LOSS_LEN(LL)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .tmds_in     (tmds_in),
    .data_out    (data_out),
    .control_out (control_out),
    .ve_out      (ve_out),
    .locked_out  (locked_out),
    .offset_out  (offset_out)
  );

  always #5 clk_in = ~clk_in;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state (plain integers and flags)
  logic [9:0] m_prev;
  int         m_off, m_run, m_hunt, m_loss;
  bit         m_lock;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;
  bit         m_ve;
  int         enc_cnt;

  task automatic model_reset();
    m_prev = '0; m_off = 0; m_run = 0; m_hunt = 0; m_loss = 0;
    m_lock = 0; m_data = '0; m_ctrl = '0; m_ve = 0;
  endtask

  function automatic int token_of(input logic [9:0] s);
    case (s)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] decode_sym(input logic [9:0] s);
    logic [7:0] d, r;
    d = s[9] ? ~s[7:0] : s[7:0];
    r[0] = d[0];
    for (int i = 1; i < 8; i++) r[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return r;
  endfunction

  task automatic model_edge(input logic [9:0] w);
    logic [19:0] win;
    logic [9:0]  al;
    int          tk;
    win = {w, m_prev};
    win = win >> m_off;
    al  = win[9:0];
    tk  = token_of(al);
    if (!m_lock) begin
      if (tk >= 0) begin
        if (m_run == LC - 1) begin m_lock = 1; m_run = 0; m_hunt = 0; m_loss = 0; end
        else m_run++;
      end else begin
        m_run = 0;
        if (m_hunt == HL - 1) begin m_off = (m_off + 1) % 10; m_hunt = 0; end
        else m_hunt++;
      end
    end else begin
      if (tk >= 0) m_loss = 0;
      else if (m_loss == LL - 1) begin m_lock = 0; m_loss = 0; m_run = 0; m_hunt = 0; end
      else m_loss++;
    end
    if (m_lock) begin
      if (tk >= 0) begin m_ve = 0; m_ctrl = 2'(tk); end
      else begin m_ve = 1; m_data = decode_sym(al); end
    end else begin
      m_ve = 0; m_ctrl = '0; m_data = '0;
    end
    m_prev = w;
  endtask

  // Drive one word, let one edge pass, compare every output against the model
  task automatic step(input logic [9:0] w);
    tmds_in = w;
    @(posedge clk_in);
    model_edge(w);
    #1;
    check("cycle", {16'h0, locked_out, offset_out, ve_out, control_out, data_out},
          {16'h0, m_lock, 4'(m_off), m_ve, m_ctrl, m_data});
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // Word seen by a deserializer whose boundary lags the serial stream by sh bits
  function automatic logic [9:0] shifted(input logic [9:0] tok, input int sh, input bit first);
    logic [19:0] t;
    if (first) t = {tok, 10'h000} << sh;
    else       t = {tok, tok} << sh;
    return t[19:10];
  endfunction

  task automatic encode(input logic [7:0] din, output logic [9:0] q);
    logic [8:0] qm;
    int n1, n1q, n0q;
    n1 = $countones(din);
    qm[0] = din[0];
    if (n1 > 4 || (n1 == 4 && din[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ din[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ din[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += (qm[8] ? 0 : -2) + n1q - n0q;
    end
  endtask

  logic [9:0] w;
  logic [7:0] prev_b;
  bit         prev_valid;

  initial begin
    rst_in  = 1'b1;
    tmds_in = '0;
    model_reset();
    repeat (3) @(negedge clk_in);
    check("reset_outputs", {16'h0, locked_out, offset_out, ve_out, control_out, data_out}, 32'h0);
    rst_in = 1'b0;

    // Aligned stream of control tokens
    for (int i = 1; i <= 20; i++) begin
      step(10'h354);
      if (i == 8) check("lock_not_yet", {31'h0, locked_out}, 32'd0);
      if (i == 9) check("lock_rise", {31'h0, locked_out}, 32'd1);
    end
    check("t1_offset", {28'h0, offset_out}, 32'd0);
    check("t1_ctrl", {30'h0, control_out}, 32'd0);
    check("t1_ve", {31'h0, ve_out}, 32'd0);

    // Control codes then data
    step(10'h0AB);
    step(10'h154); check("ctrl_01", {30'h0, control_out}, 32'd1);
    step(10'h2AB); check("ctrl_10", {30'h0, control_out}, 32'd2);
    step(10'h354); check("ctrl_11", {30'h0, control_out}, 32'd3);
    check("ctrl_ve", {31'h0, ve_out}, 32'd0);
    step(10'h100);
    step(10'h200);
    check("data_100", {24'h0, data_out}, 32'h00);
    check("data_100_ve", {31'h0, ve_out}, 32'd1);
    step(10'h354);
    check("data_200", {24'h0, data_out}, 32'hFF);
    step(10'h354);
    check("data_hold", {23'h0, ve_out, data_out}, 32'h0FF);

    // Every byte through a reference encoder, a blanking token before each block
    enc_cnt = 0;
    for (int blk = 0; blk < 16; blk++) begin
      step(10'h354);
      if (blk != 0) check("byte", {24'h0, data_out}, {24'h0, prev_b});
      enc_cnt    = 0;
      prev_valid = 0;
      for (int j = 0; j < 16; j++) begin
        encode(8'(blk * 16 + j), w);
        step(w);
        if (prev_valid) check("byte", {23'h0, ve_out, data_out}, {23'h0, 1'b1, prev_b});
        prev_b     = 8'(blk * 16 + j);
        prev_valid = 1;
      end
    end
    step(10'h354);
    check("byte", {24'h0, data_out}, {24'h0, prev_b});

    // Loss of lock after LOSS_LEN words without a token
    for (int i = 1; i <= 33; i++) begin
      step(10'h100);
      if (i == 32) check("loss_still_locked", {31'h0, locked_out}, 32'd1);
    end
    check("loss_drop", {16'h0, locked_out, offset_out, ve_out, control_out, data_out}, 32'h0);

    // Misaligned by 3 bits: hunt through offsets then lock at 3
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      step(shifted(10'h354, 3, i == 1));
      if (i == 15) check("hunt_off0", {28'h0, offset_out}, 32'd0);
      if (i == 16) check("hunt_off1", {28'h0, offset_out}, 32'd1);
      if (i == 32) check("hunt_off2", {28'h0, offset_out}, 32'd2);
      if (i == 48) check("hunt_off3", {28'h0, offset_out}, 32'd3);
      if (i == 55) check("hunt_not_locked", {31'h0, locked_out}, 32'd0);
      if (i == 56) check("hunt_locked", {31'h0, locked_out}, 32'd1);
    end
    check("hunt_final", {26'h0, locked_out, offset_out, control_out}, {26'h0, 1'b1, 4'd3, 2'b00});

    // Lock at offset 5, then reset asynchronously between edges
    do_reset();
    for (int i = 1; i <= 90; i++) step(shifted(10'h354, 5, i == 1));
    check("off5_locked", {27'h0, locked_out, offset_out}, {27'h0, 1'b1, 4'd5});
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst", {26'h0, locked_out, offset_out, ve_out}, 32'h0);
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 12; i++) step(10'h2AB);
    check("relock_ctrl", {27'h0, locked_out, control_out, 2'b00}, {27'h0, 1'b1, 2'b11, 2'b00});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
